// File: rtl/strobe_period_monitor.sv
// Strobe period monitor: measures the interval between single-cycle strobes,
// locks after LOCK_COUNT consecutive intervals equal to PERIOD, then flags
// early strobes (interval < PERIOD) and missing strobes (no strobe by PERIOD).
module strobe_period_monitor #(
   parameter int unsigned PERIOD     = 3,
   parameter int unsigned LOCK_COUNT = 4,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             strobe,
   input  logic             clear,
   output logic             locked,
   output logic             err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] period,
   output logic             period_valid
);

   localparam int unsigned GoodW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

   localparam logic [CNT_W-1:0] PeriodVal = CNT_W'(PERIOD);
   localparam logic [CNT_W-1:0] SinceOne  = CNT_W'(1);
   localparam logic [CNT_W-1:0] SinceMax  = {CNT_W{1'b1}};
   localparam logic [GoodW-1:0] LockVal   = GoodW'(LOCK_COUNT);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAcq    = 2'd1,
      StLocked = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] since_q, since_d;
   logic [GoodW-1:0] good_q, good_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             period_valid_q, period_valid_d;
   logic             err_q, err_d;
   logic             err_sticky_q, err_sticky_d;
   logic             locked_q, locked_d;

   logic [GoodW-1:0] good_inc;
   logic [CNT_W-1:0] since_inc;

   assign good_inc  = good_q + 1'b1;
   // Interval counter saturates rather than wrapping so long gaps read as max.
   assign since_inc = (since_q == SinceMax) ? since_q : since_q + 1'b1;

   // Next-state, counter and output computation; clear overrides strobe handling.
   always_comb begin
      state_d        = state_q;
      since_d        = since_q;
      good_d         = good_q;
      period_d       = period_q;
      period_valid_d = 1'b0;
      err_d          = 1'b0;

      if (clear) begin
         state_d  = StIdle;
         since_d  = '0;
         good_d   = '0;
         period_d = '0;
      end else begin
         case (state_q)
            StIdle: begin
               since_d = '0;
               if (strobe) begin
                  since_d = SinceOne;
                  good_d  = '0;
                  state_d = StAcq;
               end
            end

            StAcq: begin
               if (strobe) begin
                  period_d       = since_q;
                  period_valid_d = 1'b1;
                  since_d        = SinceOne;
                  if (since_q == PeriodVal) begin
                     good_d = good_inc;
                     if (good_inc == LockVal) begin
                        state_d = StLocked;
                     end
                  end else begin
                     // Off-period strobe just restarts the run; not an error yet.
                     good_d = '0;
                  end
               end else begin
                  since_d = since_inc;
               end
            end

            StLocked: begin
               if (strobe) begin
                  period_d       = since_q;
                  period_valid_d = 1'b1;
                  since_d        = SinceOne;
                  if (since_q != PeriodVal) begin
                     err_d   = 1'b1;
                     good_d  = '0;
                     state_d = StAcq;
                  end
               end else if (since_q == PeriodVal) begin
                  // Expected strobe slot passed empty: drop back and re-seed.
                  err_d   = 1'b1;
                  good_d  = '0;
                  since_d = '0;
                  state_d = StIdle;
               end else begin
                  since_d = since_inc;
               end
            end

            default: begin
               state_d = StIdle;
               since_d = '0;
               good_d  = '0;
            end
         endcase
      end

      err_sticky_d = clear ? 1'b0 : (err_sticky_q | err_d);
      locked_d     = (state_d == StLocked);
   end

   // State and registered outputs, asynchronously cleared by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= StIdle;
         since_q        <= '0;
         good_q         <= '0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         err_q          <= 1'b0;
         err_sticky_q   <= 1'b0;
         locked_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         since_q        <= since_d;
         good_q         <= good_d;
         period_q       <= period_d;
         period_valid_q <= period_valid_d;
         err_q          <= err_d;
         err_sticky_q   <= err_sticky_d;
         locked_q       <= locked_d;
      end
   end

   assign locked       = locked_q;
   assign err          = err_q;
   assign err_sticky   = err_sticky_q;
   assign period       = period_q;
   assign period_valid = period_valid_q;

endmodule

// File: tb/tb_strobe_period_monitor.sv
// Directed bench for strobe_period_monitor with a timestamp-based reference model.
module tb_strobe_period_monitor;

   localparam int unsigned PERIOD     = 3;
   localparam int unsigned LOCK_COUNT = 4;
   localparam int unsigned CNT_W      = 8;
   localparam int          MAXV       = (1 << CNT_W) - 1;

   logic             clk;
   logic             reset;
   logic             strobe;
   logic             clear;
   logic             locked;
   logic             err;
   logic             err_sticky;
   logic [CNT_W-1:0] period;
   logic             period_valid;

   strobe_period_monitor #(
      .PERIOD    (PERIOD),
      .LOCK_COUNT(LOCK_COUNT),
      .CNT_W     (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .strobe      (strobe),
      .clear       (clear),
      .locked      (locked),
      .err         (err),
      .err_sticky  (err_sticky),
      .period      (period),
      .period_valid(period_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_bad;

   // Model: mode 0 idle, 1 acquiring, 2 locked; intervals from timestamps.
   int mode;
   int cyc;
   int last_ts;
   int good;
   int e_period;
   bit e_pv;
   bit e_err;
   bit e_sticky;
   bit e_locked;

   int sq[$];

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mode     = 0;
      good     = 0;
      last_ts  = 0;
      e_period = 0;
      e_pv     = 0;
      e_err    = 0;
      e_sticky = 0;
      e_locked = 0;
   endtask

   task automatic model_edge(input bit s, input bit c);
      int iv;
      e_pv  = 0;
      e_err = 0;
      if (c) begin
         model_reset();
      end else if (mode == 0) begin
         if (s) begin
            mode    = 1;
            last_ts = cyc;
            good    = 0;
         end
      end else begin
         iv = cyc - last_ts;
         if (iv > MAXV) iv = MAXV;
         if (s) begin
            e_period = iv;
            e_pv     = 1;
            last_ts  = cyc;
            if (mode == 1) begin
               if (iv == PERIOD) begin
                  good++;
                  if (good == LOCK_COUNT) mode = 2;
               end else begin
                  good = 0;
               end
            end else if (iv != PERIOD) begin
               e_err = 1;
               good  = 0;
               mode  = 1;
            end
         end else if (mode == 2 && iv == PERIOD) begin
            e_err = 1;
            mode  = 0;
         end
      end
      if (e_err) e_sticky = 1;
      e_locked = (mode == 2);
      cyc++;
   endtask

   task automatic compare_all();
      chk("locked", int'(locked), int'(e_locked));
      chk("err", int'(err), int'(e_err));
      chk("err_sticky", int'(err_sticky), int'(e_sticky));
      chk("period", int'(period), e_period);
      chk("period_valid", int'(period_valid), int'(e_pv));
   endtask

   task automatic step(input bit s, input bit c);
      strobe = s;
      clear  = c;
      @(posedge clk);
      if (reset) model_reset();
      else model_edge(s, c);
      #1;
      compare_all();
   endtask

   task automatic play(input int len);
      bit s;
      for (int i = 0; i < len; i++) begin
         s = 0;
         foreach (sq[k]) if (sq[k] == i) s = 1;
         step(s, 1'b0);
      end
   endtask

   task automatic lock_seq();
      sq = '{0, 3, 6, 9, 12};
      play(13);
   endtask

   initial begin
      n_vec  = 0;
      n_bad  = 0;
      cyc    = 0;
      reset  = 1'b1;
      strobe = 1'b0;
      clear  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_locked", int'(locked), 0);
      chk("rst_err_sticky", int'(err_sticky), 0);
      chk("rst_period", int'(period), 0);
      chk("rst_pv", int'(period_valid), 0);
      reset = 1'b0;

      // Lock, then missing strobe.
      lock_seq();
      chk("lock_locked", int'(locked), 1);
      chk("lock_period", int'(period), 3);
      chk("lock_pv", int'(period_valid), 1);
      chk("lock_sticky", int'(err_sticky), 0);
      sq = '{};
      play(2);
      chk("miss_pre_err", int'(err), 0);
      play(1);
      chk("miss_err", int'(err), 1);
      chk("miss_locked", int'(locked), 0);
      play(1);
      chk("miss_err_once", int'(err), 0);
      chk("miss_sticky", int'(err_sticky), 1);

      // Relock with sticky set, then clear together with a strobe.
      lock_seq();
      chk("relock_locked", int'(locked), 1);
      step(1'b1, 1'b1);
      chk("clr_locked", int'(locked), 0);
      chk("clr_sticky", int'(err_sticky), 0);
      chk("clr_period", int'(period), 0);

      // Early strobe, then resume and relock.
      sq = '{0, 3, 6, 9, 12, 14};
      play(15);
      chk("early_err", int'(err), 1);
      chk("early_period", int'(period), 2);
      chk("early_pv", int'(period_valid), 1);
      chk("early_locked", int'(locked), 0);
      sq = '{2, 5, 8, 11};
      play(12);
      chk("resume_locked", int'(locked), 1);

      // Acquire disturbance.
      step(1'b0, 1'b1);
      sq = '{0, 3, 5, 8, 11, 14};
      play(17);
      chk("dist_not_locked", int'(locked), 0);
      sq = '{0};
      play(1);
      chk("dist_locked", int'(locked), 1);
      chk("dist_sticky", int'(err_sticky), 0);

      // Saturation.
      step(1'b0, 1'b1);
      sq = '{0, 300};
      play(301);
      chk("sat_period", int'(period), 255);
      chk("sat_locked", int'(locked), 0);
      chk("sat_sticky", int'(err_sticky), 0);

      // Strobe held high after lock.
      step(1'b0, 1'b1);
      sq = '{0, 3, 6, 9, 12, 13, 14, 15};
      play(16);
      chk("held_locked", int'(locked), 0);
      chk("held_period", int'(period), 1);

      // Asynchronous reset mid-interval; strobe during reset ignored.
      step(1'b0, 1'b1);
      sq = '{0, 3};
      play(5);
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      chk("arst_sticky", int'(err_sticky), 0);
      chk("arst_period", int'(period), 0);
      chk("arst_locked", int'(locked), 0);
      step(1'b1, 1'b0);
      reset = 1'b0;
      step(1'b0, 1'b0);
      chk("arst_pv", int'(period_valid), 0);

      // Divide-by-3 generator.
      sq = '{};
      for (int i = 0; i < 40; i++) if (i % 3 == 0) sq.push_back(i);
      play(40);
      chk("div3_locked", int'(locked), 1);
      chk("div3_sticky", int'(err_sticky), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/strobe_period_monitor.md
# strobe_period_monitor

Receive-side checker for a periodic single-cycle strobe, such as the output of a divide-by-N clock-enable generator. It measures the cycle interval between strobes and declares lock after a run of intervals equal to `PERIOD`. Once locked, it flags early and missing strobes. It is intended as an on-chip monitor for strobe generators and as a reusable checker in benches.

## Interface

**Parameters**
- `PERIOD`, default 3: expected strobe interval in clk cycles. Legal range is 2 to 2^CNT_W−1.
- `LOCK_COUNT`, default 4: number of consecutive correct intervals required to lock. Must be ≥1.
- `CNT_W`, default 8: width of the interval counter and of `period`.

**Ports**
- `clk`, input, 1: clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `strobe`, input, 1: monitored strobe, sampled every cycle.
- `clear`, input, 1: synchronous reset of all state, including `err_sticky`.
- `locked`, output, 1: high while the FSM is in LOCKED.
- `err`, output, 1: one-cycle pulse per detected early or missing strobe.
- `err_sticky`, output, 1: set by any `err`; cleared only by `reset` or `clear`.
- `period`, output, CNT_W: last measured interval.
- `period_valid`, output, 1: one-cycle pulse when `period` updates.

## Operation

**Internal state**
- FSM state: IDLE, ACQ or LOCKED.
- `since` (CNT_W): cycles elapsed since the last strobe. It increments each non-strobe cycle in ACQ/LOCKED and saturates at 2^CNT_W−1.
- `good`: count of consecutive correct intervals, 0 to LOCK_COUNT.

**Interval measurement**
- The interval equals the value of `since` in the strobe cycle.
- On every strobe outside IDLE, `since` is loaded with 1.
- Example: strobes sampled at cycles 0 and 3 give an interval of 3.

**IDLE**
- The counter is held at 0.
- On `strobe`: `since`←1, `good`←0, go to ACQ. No `period_valid`.

**ACQ, on a strobe**
- `period`←interval and `period_valid` pulses.
- If interval == PERIOD: `good`←`good`+1. If the new value equals LOCK_COUNT, go to LOCKED.
- Otherwise: `good`←0 and stay in ACQ. No `err`.
- The offending strobe becomes the new reference.

**ACQ, no strobe**
- Count only. Saturation is not an error.

**LOCKED, on a strobe**
- `period`←interval and `period_valid` pulses.
- If interval == PERIOD: stay in LOCKED.
- If interval < PERIOD (early strobe): assert `err`, set `err_sticky`, `good`←0, go to ACQ.

**LOCKED, no strobe**
- If `since` == PERIOD (missing strobe): assert `err`, set `err_sticky`, go to IDLE.
- A late strobe is therefore never measured. It re-seeds from IDLE.

**Priority and outputs**
- Priority order: `reset` > `clear` > `strobe` logic.
- `clear` returns the block to IDLE with all counters, `period` and `err_sticky` at 0. A `strobe` in the same cycle as `clear` is ignored.
- `locked` is a Moore output of the state register; it is not decoded from `since`.

## Timing

- All outputs are registered. A response to the input sampled at edge n is visible after edge n ("cycle n+1").
- Reset values: `locked`=0, `err`=0, `err_sticky`=0, `period`=0, `period_valid`=0. State is IDLE; `since` and `good` are 0.
- `locked` rises one cycle after the strobe that completes the LOCK_COUNT-th good interval.
- `locked` falls in the same cycle that `err` pulses.
- `period`, `period_valid` and `err` update together on the strobe that produced the measurement.
- `err` is never high for two consecutive cycles from a single event.
- Minimum time to lock from IDLE: LOCK_COUNT×PERIOD+1 cycles after the first strobe.
- `strobe` held high continuously gives an interval of 1 every cycle. This never locks for PERIOD≥2; in LOCKED it produces `err` and then stays in ACQ.
- Asserting `reset` mid-operation clears everything immediately. A `strobe` during reset is ignored.

## Test plan

1. **Lock:** PERIOD=3, LOCK_COUNT=4, strobes at cycles 0,3,6,9,12 → `period_valid` in cycles 4,7,10,13 with `period`=3; `locked`=1 from cycle 13; `err` never asserted.
2. **Missing:** lock as in 1, then no strobe after cycle 12 → `err`=1 in cycle 16 only; `locked`=0 from 16; `err_sticky` stays 1; state IDLE.
3. **Early:** lock, then strobes at 12 and 14 → cycle 15: `err`=1, `period`=2, `period_valid`=1, `locked`=0. Strobes then resume at 17,20,23,26 → `locked`=1 again in cycle 27.
4. **Acquire disturbance:** strobes at 0,3,5,8,11,14,17 → no `err`; `good` resets at 5; `locked`=1 in cycle 18.
5. **Saturation:** CNT_W=8, strobes at 0 and 300 → `period`=255 in cycle 301; no `err`; not locked.
6. **Clear/reset:** `clear` while locked with `err_sticky`=1 → next cycle all outputs 0, state IDLE. Asynchronous `reset` mid-interval → outputs 0 immediately, not at the next edge. Also run with `strobe` driven by a divide-by-3 generator → locks and never errs.
